// File: rtl/mram_serial_burst_ctrl.sv
// rtl/mram_serial_burst_ctrl.sv - serial-fed burst read/write controller for an async MRAM.
module mram_serial_burst_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int T_WR   = 3,
  parameter int T_RD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              read_write_sel,
  input  logic [3:0]        burst_len,
  input  logic              addr_in,
  input  logic              data_in,
  input  logic [DATA_W-1:0] parallel_data_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              ser_data_out,
  output logic              ser_valid,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    SH_ADDR,
    SH_DATA,
    WR_PULSE,
    RD_WAIT,
    SH_OUT,
    NEXT,
    FINISH
  } state_t;

  // One shared phase counter sized for the longest phase of any state.
  localparam int LEN_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int LEN_T   = (T_WR > T_RD) ? T_WR : T_RD;
  localparam int LEN_MAX = (LEN_AD > LEN_T) ? LEN_AD : LEN_T;
  localparam int CNT_W   = $clog2(LEN_MAX + 1);

  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        words_left;
  logic              mode_wr;
  logic [DATA_W-1:0] rd_shift;
  logic              lower_en_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      words_left <= '0;
      mode_wr    <= 1'b0;
      addr_out   <= '0;
      data_out   <= '0;
      rd_shift   <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || (state == IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (start) begin
            mode_wr    <= read_write_sel;
            words_left <= burst_len;
          end
        end
        SH_ADDR:  addr_out <= {addr_in, addr_out[ADDR_W-1:1]};
        SH_DATA:  data_out <= {data_in, data_out[DATA_W-1:1]};
        RD_WAIT: begin
          if (cnt == RD_LAST) begin
            rd_shift <= parallel_data_in;
          end
        end
        SH_OUT:   rd_shift <= rd_shift >> 1;
        NEXT: begin
          // Address wraps naturally at the bus width.
          if (words_left != 4'd0) begin
            words_left <= words_left - 4'd1;
            addr_out   <= addr_out + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    chip_en      = 1'b1;
    write_en     = 1'b1;
    out_en       = 1'b1;
    lower_en_n   = 1'b1;
    ser_valid    = 1'b0;
    ser_data_out = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_next = SH_ADDR;
      end
      SH_ADDR: begin
        if (cnt == ADDR_LAST) state_next = mode_wr ? SH_DATA : RD_WAIT;
      end
      SH_DATA: begin
        if (cnt == DATA_LAST) state_next = WR_PULSE;
      end
      WR_PULSE: begin
        chip_en    = 1'b0;
        write_en   = 1'b0;
        lower_en_n = 1'b0;
        if (cnt == WR_LAST) state_next = NEXT;
      end
      RD_WAIT: begin
        chip_en    = 1'b0;
        out_en     = 1'b0;
        lower_en_n = 1'b0;
        if (cnt == RD_LAST) state_next = SH_OUT;
      end
      SH_OUT: begin
        ser_valid    = 1'b1;
        ser_data_out = rd_shift[0];
        if (cnt == DATA_LAST) state_next = NEXT;
      end
      NEXT: begin
        if (words_left != 4'd0) begin
          state_next = mode_wr ? SH_DATA : RD_WAIT;
        end else begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A byte-wide part has no upper lane, so its enable is held off.
  assign lower_byte_en = lower_en_n;
  assign upper_byte_en = (DATA_W == 8) ? 1'b1 : lower_en_n;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mram_serial_burst_ctrl.sv
// tb/tb_mram_serial_burst_ctrl.sv - scoreboard bench for mram_serial_burst_ctrl.
module tb_mram_serial_burst_ctrl;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int TW = 3;
  localparam int TR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, start = 1'b0, sel = 1'b0, addr_in = 1'b0, data_in = 1'b0;
  logic [3:0]    blen = 4'd0;
  logic [DW-1:0] pdi, data_out;
  logic [AW-1:0] addr_out;
  logic          ser_data_out, ser_valid, chip_en, write_en, out_en, lbe, ube, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    logic [31:0] h;
    h = 32'(a) * 32'd40503 ^ 32'h5a5a1234;
    return (a == AW'(16)) ? 16'h1234 : h[23:8];
  endfunction
  assign pdi = mem_fn(addr_out);

  mram_serial_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .T_WR(TW), .T_RD(TR)) u_dut (
    .clk(clk), .rst(rst), .start(start), .read_write_sel(sel), .burst_len(blen),
    .addr_in(addr_in), .data_in(data_in), .parallel_data_in(pdi),
    .addr_out(addr_out), .data_out(data_out), .ser_data_out(ser_data_out),
    .ser_valid(ser_valid), .chip_en(chip_en), .write_en(write_en), .out_en(out_en),
    .lower_byte_en(lbe), .upper_byte_en(ube), .busy(busy), .done(done)
  );

  logic          start8 = 1'b0, sel8 = 1'b0, ain8 = 1'b0, din8 = 1'b0;
  logic [3:0]    blen8 = 4'd0;
  logic [7:0]    pdi8, data8;
  logic [AW-1:0] addr8;
  logic          ser8, sv8, ce8, we8, oe8, lbe8, ube8, busy8, done8;
  assign pdi8 = addr8[7:0];

  mram_serial_burst_ctrl #(.DATA_W(8), .ADDR_W(AW), .T_WR(TW), .T_RD(TR)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .read_write_sel(sel8), .burst_len(blen8),
    .addr_in(ain8), .data_in(din8), .parallel_data_in(pdi8),
    .addr_out(addr8), .data_out(data8), .ser_data_out(ser8),
    .ser_valid(sv8), .chip_en(ce8), .write_en(we8), .out_en(oe8),
    .lower_byte_en(lbe8), .upper_byte_en(ube8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            len;
  } wr_t;

  wr_t           wr_q[$];
  logic [DW-1:0] rd_q[$];
  int            done_q[$];

  // Monitor: pops expectations whenever the DUT presents an observable event.
  bit            in_pulse = 1'b0;
  int            plen = 0, cur_len = 0, rcnt = 0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data, rword;
  wr_t           e;

  always @(negedge clk) begin
    chk("we_oe_exclusive", 64'(write_en | out_en), 64'd1);
    if (!ser_valid) chk("ser_idle_zero", 64'(ser_data_out), 64'd0);
    if (!out_en) chk("rd_ctrl", 64'({chip_en, lbe, ube, write_en}), 64'b0001);
    if (!write_en) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        plen     = 0;
        p_addr   = addr_out;
        p_data   = data_out;
        if (wr_q.size() == 0) begin
          total++; bad++; cur_len = TW;
          $display("FAIL unexpected_write: addr=%0h data=%0h", addr_out, data_out);
        end else begin
          e = wr_q.pop_front();
          cur_len = e.len;
          chk("wr_addr", 64'(addr_out), 64'(e.a));
          chk("wr_data", 64'(data_out), 64'(e.d));
        end
      end else begin
        chk("wr_addr_stable", 64'(addr_out), 64'(p_addr));
        chk("wr_data_stable", 64'(data_out), 64'(p_data));
      end
      chk("wr_ctrl", 64'({chip_en, lbe, ube, out_en}), 64'b0001);
      plen++;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      chk("wr_pulse_len", 64'(plen), 64'(cur_len));
    end
    if (ser_valid) begin
      rword[rcnt] = ser_data_out;
      rcnt++;
      if (rcnt == DW) begin
        rcnt = 0;
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_read: word=%0h", rword);
        end else begin
          chk("rd_word", 64'(rword), 64'(rd_q.pop_front()));
        end
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: cycle=%0d expected none", cyc);
      end else begin
        chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  int ube8_low = 0, we8_cycles = 0, good8 = 0, done8_cnt = 0;
  always @(negedge clk) begin
    if (!ube8) ube8_low++;
    if (!we8) begin
      we8_cycles++;
      if (!lbe8 && !ce8 && oe8 && data8 == 8'h5A && addr8 == AW'(20'h00123)) good8++;
    end
    if (done8) done8_cnt++;
  end

  logic [DW-1:0] wdata [16];

  // Reference latency: start cycle, address phase, per-word phases plus NEXT, then FINISH.
  function automatic int lat(input bit wr, input int len);
    int per_word;
    per_word = wr ? (DW + TW + 1) : (TR + DW + 1);
    return 1 + AW + (len + 1) * per_word + 1;
  endfunction

  task automatic begin_burst(input bit wr, input int len, input logic [AW-1:0] a,
                             input int pl, input bit exp_done);
    int s;
    wr_t w;
    @(posedge clk); #1;
    start = 1'b1; sel = wr; blen = 4'(len); s = cyc;
    for (int i = 0; i <= len; i++) begin
      if (wr) begin
        w.a = a + AW'(i); w.d = wdata[i]; w.len = pl;
        wr_q.push_back(w);
      end else begin
        rd_q.push_back(mem_fn(a + AW'(i)));
      end
    end
    if (exp_done) done_q.push_back(s + lat(wr, len) - 1);
    @(posedge clk); #1;
    start = 1'b0; sel = 1'($urandom); blen = 4'($urandom);
    for (int i = 0; i < AW; i++) begin
      addr_in = a[i];
      @(posedge clk); #1;
    end
    addr_in = 1'b0;
  endtask

  task automatic drive_word(input logic [DW-1:0] d);
    for (int b = 0; b < DW; b++) begin
      data_in = d[b];
      @(posedge clk); #1;
    end
    data_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((busy || done_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("burst_complete", 64'(busy || done_q.size() != 0), 64'd0);
    chk("queues_drained", 64'(wr_q.size() + rd_q.size()), 64'd0);
  endtask

  task automatic run(input bit wr, input int len, input logic [AW-1:0] a, input bit inject);
    begin_burst(wr, len, a, TW, 1'b1);
    if (wr) begin
      for (int w = 0; w <= len; w++) begin
        drive_word(wdata[w]);
        repeat (TW + 1) begin @(posedge clk); #1; end
      end
    end else if (inject) begin
      repeat (3) begin @(posedge clk); #1; end
      start = 1'b1; sel = 1'b1; blen = 4'hF;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(600);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'({addr_out, data_out, ser_data_out, ser_valid, busy, done,
                            chip_en, write_en, out_en, lbe, ube}), 64'h1F);
    @(posedge clk); #1;
    rst = 1'b0;

    wdata[0] = 16'hA5C3;
    run(1'b1, 0, AW'(20'h003FF), 1'b0);
    run(1'b0, 0, AW'(20'h00010), 1'b0);
    for (int i = 0; i < 4; i++) wdata[i] = DW'($urandom);
    run(1'b1, 3, AW'(20'hFFFFE), 1'b0);
    run(1'b0, 2, AW'($urandom), 1'b1);

    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; sel = 1'b1; blen = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_over_start", 64'({busy, write_en}), 64'b01);

    for (int k = 0; k < 10; k++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 2) == 0) ? AW'(20'hFFFFF - 20'($urandom_range(0, 2))) : AW'($urandom);
      for (int i = 0; i < 16; i++) wdata[i] = DW'($urandom);
      run(1'($urandom), $urandom_range(0, 3), a, 1'($urandom));
    end

    wdata[0] = DW'($urandom);
    begin_burst(1'b1, 0, AW'($urandom), 2, 1'b0);
    drive_word(wdata[0]);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_pulse", 64'({write_en, busy, addr_out}), 64'({1'b1, 1'b0, {AW{1'b0}}}));
    repeat (60) @(negedge clk);
    chk("rst_no_leftover", 64'(wr_q.size() + done_q.size()), 64'd0);

    run(1'b0, 1, AW'(20'h0000F), 1'b0);

    @(posedge clk); #1;
    ube8_low = 0; we8_cycles = 0; good8 = 0; done8_cnt = 0;
    start8 = 1'b1; sel8 = 1'b1; blen8 = 4'd0;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < AW; i++) begin
      ain8 = 1'(20'h00123 >> i);
      @(posedge clk); #1;
    end
    ain8 = 1'b0;
    for (int b = 0; b < 8; b++) begin
      din8 = 1'(8'h5A >> b);
      @(posedge clk); #1;
    end
    din8 = 1'b0;
    for (int n = 0; n < 50 && busy8; n++) @(negedge clk);
    @(negedge clk);
    chk("w8_upper_never_low", 64'(ube8_low), 64'd0);
    chk("w8_pulse_cycles", 64'(we8_cycles), 64'(TW));
    chk("w8_pulse_lower_data", 64'(good8), 64'(TW));
    chk("w8_done_once", 64'(done8_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: cycle=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

endmodule
